// File: rtl/fft16_bf_scheduler_if.sv
// rtl/fft16_bf_scheduler_if.sv - load stream, butterfly operand/result bus and output stream of the FFT scheduler
interface fft16_bf_scheduler_if #(
  parameter int WORD_SIZE = 16
);
  logic                        i_load_valid;
  logic signed [WORD_SIZE-1:0] i_load_re;
  logic signed [WORD_SIZE-1:0] i_load_im;
  logic                        o_load_ready;
  logic signed [WORD_SIZE-1:0] o_bf_in0_re;
  logic signed [WORD_SIZE-1:0] o_bf_in0_im;
  logic signed [WORD_SIZE-1:0] o_bf_in1_re;
  logic signed [WORD_SIZE-1:0] o_bf_in1_im;
  logic signed [WORD_SIZE-1:0] o_bf_tw_re;
  logic signed [WORD_SIZE-1:0] o_bf_tw_im;
  logic signed [WORD_SIZE-1:0] i_bf_out0_re;
  logic signed [WORD_SIZE-1:0] i_bf_out0_im;
  logic signed [WORD_SIZE-1:0] i_bf_out1_re;
  logic signed [WORD_SIZE-1:0] i_bf_out1_im;
  logic                        i_bf_done;
  logic                        o_out_valid;
  logic signed [WORD_SIZE-1:0] o_out_re;
  logic signed [WORD_SIZE-1:0] o_out_im;
  logic [3:0]                  o_out_index;
  logic                        o_out_last;
  logic                        i_out_ready;
  logic                        o_busy;

  modport master (
    input  i_load_valid, i_load_re, i_load_im,
    output o_load_ready,
    output o_bf_in0_re, o_bf_in0_im, o_bf_in1_re, o_bf_in1_im, o_bf_tw_re, o_bf_tw_im,
    input  i_bf_out0_re, i_bf_out0_im, i_bf_out1_re, i_bf_out1_im, i_bf_done,
    output o_out_valid, o_out_re, o_out_im, o_out_index, o_out_last,
    input  i_out_ready,
    output o_busy
  );

  modport slave (
    output i_load_valid, i_load_re, i_load_im,
    input  o_load_ready,
    input  o_bf_in0_re, o_bf_in0_im, o_bf_in1_re, o_bf_in1_im, o_bf_tw_re, o_bf_tw_im,
    output i_bf_out0_re, i_bf_out0_im, i_bf_out1_re, i_bf_out1_im, i_bf_done,
    input  o_out_valid, o_out_re, o_out_im, o_out_index, o_out_last,
    output i_out_ready,
    input  o_busy
  );
endinterface

// File: rtl/fft16_bf_scheduler.sv
// rtl/fft16_bf_scheduler.sv - 16-point radix-2 DIT FFT scheduler around an external butterfly2
// Optional FFT_SCALE_EN: halve every write-back result (output = DFT/16).
module fft16_bf_scheduler #(
  parameter int WORD_SIZE = 16,
  parameter int FRACTION  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  fft16_bf_scheduler_if.master  bus
);
  typedef logic signed [WORD_SIZE-1:0] word_t;
  typedef enum logic [2:0] {
    LOAD = 3'd0, ISSUE = 3'd1, WAIT = 3'd2, WB = 3'd3, UNLOAD = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d, idx_q, idx_d;
  logic [1:0] s_q, s_d;
  logic [2:0] b_q, b_d;
  logic       edge_q, edge_d, ready_q, ready_d, valid_q, valid_d, last_q, last_d;
  logic [1:0] done_sync_q;
  logic       done_prev_q;
  word_t      in0_re_q, in0_re_d, in0_im_q, in0_im_d, in1_re_q, in1_re_d, in1_im_q, in1_im_d;
  word_t      tw_re_q, tw_re_d, tw_im_q, tw_im_d, out_re_q, out_re_d, out_im_q, out_im_d;
  word_t      ram_re [16];
  word_t      ram_im [16];
  logic       ld_we, wb_we, rise;
  logic [3:0] span, pos, i0, i1, nxt;
  logic [2:0] kk;

  function automatic word_t rom_re(input logic [2:0] k);
    word_t v;
    case (k)
      3'd0: v = word_t'(256);   3'd1: v = word_t'(237);
      3'd2: v = word_t'(181);   3'd3: v = word_t'(98);
      3'd4: v = word_t'(0);     3'd5: v = word_t'(-98);
      3'd6: v = word_t'(-181);  default: v = word_t'(-237);
    endcase
    return v <<< (FRACTION - 8);
  endfunction

  function automatic word_t rom_im(input logic [2:0] k);
    word_t v;
    case (k)
      3'd0: v = word_t'(0);     3'd1: v = word_t'(-98);
      3'd2: v = word_t'(-181);  3'd3: v = word_t'(-237);
      3'd4: v = word_t'(-256);  3'd5: v = word_t'(-237);
      3'd6: v = word_t'(-181);  default: v = word_t'(-98);
    endcase
    return v <<< (FRACTION - 8);
  endfunction

  function automatic word_t wb_val(input word_t x);
`ifdef FFT_SCALE_EN
    return x >>> 1;
`else
    return x;
`endif
  endfunction

  // Butterfly addressing for stage s, butterfly b; unchanged from ISSUE until WB.
  assign span = 4'd1 << s_q;
  assign pos  = {1'b0, b_q} & (span - 4'd1);
  assign i0   = (({1'b0, b_q} >> s_q) << ({1'b0, s_q} + 3'd1)) + pos;
  assign i1   = i0 + span;
  assign kk   = 3'(pos << (3'd3 - {1'b0, s_q}));
  assign nxt  = idx_q + 4'd1;
  assign rise = done_sync_q[1] & ~done_prev_q;

  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;  idx_d = idx_q;  s_d = s_q;  b_d = b_q;
    edge_d = edge_q;    ready_d = ready_q;  valid_d = valid_q;  last_d = last_q;
    in0_re_d = in0_re_q;  in0_im_d = in0_im_q;  in1_re_d = in1_re_q;  in1_im_d = in1_im_q;
    tw_re_d = tw_re_q;    tw_im_d = tw_im_q;    out_re_d = out_re_q;  out_im_d = out_im_q;
    ld_we = 1'b0;  wb_we = 1'b0;
    case (state_q)
      LOAD: if (bus.i_load_valid && ready_q) begin
        ld_we = 1'b1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          ready_d = 1'b0;  s_d = 2'd0;  b_d = 3'd0;  state_d = ISSUE;
        end
      end
      ISSUE: begin
        in0_re_d = ram_re[i0];  in0_im_d = ram_im[i0];
        in1_re_d = ram_re[i1];  in1_im_d = ram_im[i1];
        tw_re_d  = rom_re(kk);  tw_im_d  = rom_im(kk);
        edge_d = 1'b0;  state_d = WAIT;
      end
      // The first edge may end a period that started before the operands settled.
      WAIT: if (rise) begin
        if (!edge_q) edge_d = 1'b1;
        else         state_d = WB;
      end
      WB: begin
        wb_we = 1'b1;
        b_d = b_q + 3'd1;
        if (b_q == 3'd7) s_d = s_q + 2'd1;
        if (b_q == 3'd7 && s_q == 2'd3) begin
          state_d = UNLOAD;  idx_d = 4'd0;  valid_d = 1'b0;
        end else begin
          state_d = ISSUE;
        end
      end
      UNLOAD: begin
        if (!valid_q) begin
          out_re_d = ram_re[idx_q];  out_im_d = ram_im[idx_q];
          valid_d = 1'b1;  last_d = (idx_q == 4'd15);
        end else if (bus.i_out_ready) begin
          if (last_q) begin
            valid_d = 1'b0;  last_d = 1'b0;  cnt_d = 4'd0;  ready_d = 1'b1;  state_d = LOAD;
          end else begin
            idx_d = nxt;  out_re_d = ram_re[nxt];  out_im_d = ram_im[nxt];
            last_d = (idx_q == 4'd14);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= LOAD;  cnt_q <= 4'd0;  idx_q <= 4'd0;  s_q <= 2'd0;  b_q <= 3'd0;
      edge_q <= 1'b0;   ready_q <= 1'b1;  valid_q <= 1'b0;  last_q <= 1'b0;
      done_sync_q <= 2'b00;  done_prev_q <= 1'b0;
      in0_re_q <= '0;  in0_im_q <= '0;  in1_re_q <= '0;  in1_im_q <= '0;
      tw_re_q  <= '0;  tw_im_q  <= '0;  out_re_q <= '0;  out_im_q <= '0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;  idx_q <= idx_d;  s_q <= s_d;  b_q <= b_d;
      edge_q <= edge_d;    ready_q <= ready_d;  valid_q <= valid_d;  last_q <= last_d;
      done_sync_q <= {done_sync_q[0], bus.i_bf_done};
      done_prev_q <= done_sync_q[1];
      in0_re_q <= in0_re_d;  in0_im_q <= in0_im_d;  in1_re_q <= in1_re_d;  in1_im_q <= in1_im_d;
      tw_re_q  <= tw_re_d;   tw_im_q  <= tw_im_d;   out_re_q <= out_re_d;  out_im_q <= out_im_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (ld_we) begin
      ram_re[{cnt_q[0], cnt_q[1], cnt_q[2], cnt_q[3]}] <= bus.i_load_re;
      ram_im[{cnt_q[0], cnt_q[1], cnt_q[2], cnt_q[3]}] <= bus.i_load_im;
    end
    if (wb_we) begin
      ram_re[i0] <= wb_val(bus.i_bf_out0_re);  ram_im[i0] <= wb_val(bus.i_bf_out0_im);
      ram_re[i1] <= wb_val(bus.i_bf_out1_re);  ram_im[i1] <= wb_val(bus.i_bf_out1_im);
    end
  end

  assign bus.o_load_ready = ready_q;
  assign bus.o_bf_in0_re  = in0_re_q;
  assign bus.o_bf_in0_im  = in0_im_q;
  assign bus.o_bf_in1_re  = in1_re_q;
  assign bus.o_bf_in1_im  = in1_im_q;
  assign bus.o_bf_tw_re   = tw_re_q;
  assign bus.o_bf_tw_im   = tw_im_q;
  assign bus.o_out_valid  = valid_q;
  assign bus.o_out_re     = out_re_q;
  assign bus.o_out_im     = out_im_q;
  assign bus.o_out_index  = idx_q;
  assign bus.o_out_last   = last_q;
  assign bus.o_busy       = (state_q != LOAD);
endmodule

// File: tb/tb_fft16_bf_scheduler.sv
// tb/tb_fft16_bf_scheduler.sv - scoreboard bench for fft16_bf_scheduler with a behavioural butterfly2
// Expected bins follow FFT_SCALE_EN (divided by 16 when defined).
module tb_fft16_bf_scheduler;
  typedef struct {
    int re;
    int im;
    int idx;
    int last;
    int tol;
  } exp_t;

`ifdef FFT_SCALE_EN
  localparam int SH = 4;
`else
  localparam int SH = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft16_bf_scheduler_if #(.WORD_SIZE(16)) bus ();
  fft16_bf_scheduler #(.WORD_SIZE(16), .FRACTION(8)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  int   xr[16], xi[16], er[16], ei[16];
  int   busy_ready_bad;
  int   pr, pi;
  int   dcnt = 0;

  // Butterfly2 with round-to-nearest product; done pulses 2 of every 7 cycles.
  always_comb begin
    pr = (int'(bus.o_bf_in1_re) * int'(bus.o_bf_tw_re) - int'(bus.o_bf_in1_im) * int'(bus.o_bf_tw_im) + 128) >>> 8;
    pi = (int'(bus.o_bf_in1_re) * int'(bus.o_bf_tw_im) + int'(bus.o_bf_in1_im) * int'(bus.o_bf_tw_re) + 128) >>> 8;
    bus.i_bf_out0_re = 16'(int'(bus.o_bf_in0_re) + pr);
    bus.i_bf_out0_im = 16'(int'(bus.o_bf_in0_im) + pi);
    bus.i_bf_out1_re = 16'(int'(bus.o_bf_in0_re) - pr);
    bus.i_bf_out1_im = 16'(int'(bus.o_bf_in0_im) - pi);
  end

  always @(posedge clk) begin
    dcnt <= (dcnt == 6) ? 0 : dcnt + 1;
    bus.i_bf_done <= (dcnt < 2);
  end

  task automatic check(input string name, input int act, input int exp, input int tol);
    tests++;
    if (act > exp + tol || act < exp - tol) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d)", name, act, exp, tol);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.o_out_valid && bus.i_out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL extra_bin: got index %0d, expected no output", bus.o_out_index);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("bin_index", int'(bus.o_out_index), e.idx, 0);
        check("bin_last", int'(bus.o_out_last), e.last, 0);
        check("bin_re", int'(bus.o_out_re), e.re, e.tol);
        check("bin_im", int'(bus.o_out_im), e.im, e.tol);
      end
    end
  end

  task automatic push_expected(input int tol);
    for (int i = 0; i < 16; i++) begin
      exp_t e;
      e.re = er[i] >>> SH;
      e.im = ei[i] >>> SH;
      e.idx = i;
      e.last = (i == 15) ? 1 : 0;
      e.tol = tol;
      sb.push_back(e);
    end
  endtask

  task automatic load_frame(input bit hold);
    for (int i = 0; i < 16; i++) begin
      int t = 0;
      bus.i_load_valid = 1'b1;
      bus.i_load_re = 16'(xr[i]);
      bus.i_load_im = 16'(xi[i]);
      @(negedge clk);
      while (!bus.o_load_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) check("load_ready_timeout", 0, 1, 0);
      @(posedge clk);
      #1;
    end
    if (hold) begin
      bus.i_load_re = 16'h7f00;
      bus.i_load_im = 16'h7f00;
    end else begin
      bus.i_load_valid = 1'b0;
    end
  endtask

  task automatic finish_frame(input bit bp);
    int  t = 0;
    bit  done = 0;
    busy_ready_bad = 0;
    while (!done && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
      bus.i_out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.o_busy && bus.o_load_ready) busy_ready_bad = 1;
      if (sb.size() == 0 && !bus.o_busy) done = 1;
    end
    bus.i_load_valid = 1'b0;
    bus.i_out_ready = 1'b0;
    check("frame_done", int'(done), 1, 0);
    check("ready_low_while_busy", busy_ready_bad, 0, 0);
  endtask

  task automatic set_impulse();
    for (int i = 0; i < 16; i++) begin
      xr[i] = (i == 0) ? 256 : 0;  xi[i] = 0;
      er[i] = 256;                 ei[i] = 0;
    end
  endtask

  task automatic set_dc();
    for (int i = 0; i < 16; i++) begin
      xr[i] = 256;  xi[i] = 0;
      er[i] = (i == 0) ? 4096 : 0;  ei[i] = 0;
    end
  endtask

  initial begin
    int cosv[16] = '{256, 237, 181, 98, 0, -98, -181, -237, -256, -237, -181, -98, 0, 98, 181, 237};
    int sinv[16] = '{0, 98, 181, 237, 256, 237, 181, 98, 0, -98, -181, -237, -256, -237, -181, -98};
    int t;
    bus.i_load_valid = 1'b0;
    bus.i_load_re = '0;
    bus.i_load_im = '0;
    bus.i_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_load_ready", int'(bus.o_load_ready), 1, 0);
    check("rst_busy", int'(bus.o_busy), 0, 0);
    check("rst_out_valid", int'(bus.o_out_valid), 0, 0);
    check("rst_bf_tw_re", int'(bus.o_bf_tw_re), 0, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    set_impulse();
    push_expected(0);
    load_frame(0);
    finish_frame(0);

    set_dc();
    push_expected(0);
    load_frame(0);
    finish_frame(0);

    for (int i = 0; i < 16; i++) begin
      xr[i] = cosv[i];  xi[i] = 0;
      er[i] = (i == 1 || i == 15) ? 2048 : 0;  ei[i] = 0;
    end
    push_expected(6);
    load_frame(0);
    finish_frame(0);

    // x[1]=256 gives X[k] = 256*W16^k; drained under random backpressure.
    for (int i = 0; i < 16; i++) begin
      xr[i] = (i == 1) ? 256 : 0;  xi[i] = 0;
      er[i] = cosv[i];             ei[i] = -sinv[i];
    end
    push_expected(6);
    load_frame(0);
    finish_frame(1);

    set_dc();
    push_expected(0);
    load_frame(1);
    finish_frame(0);

    set_impulse();
    load_frame(0);
    t = 0;
    while (!(dut.s_q == 2'd2 && dut.state_q == 3'd2) && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("reach_wait_s2", (t < 5000) ? 1 : 0, 1, 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_load_ready", int'(bus.o_load_ready), 1, 0);
    check("midrst_busy", int'(bus.o_busy), 0, 0);
    check("midrst_out_valid", int'(bus.o_out_valid), 0, 0);
    check("midrst_bf_in0_re", int'(bus.o_bf_in0_re), 0, 0);
    check("midrst_out_re", int'(bus.o_out_re), 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    set_dc();
    push_expected(0);
    load_frame(0);
    finish_frame(0);

    check("scoreboard_empty", sb.size(), 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
